// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory access controller: MMIO device decode plus external req/ack memory with timeout.
// Optional device decode is enabled by defining LC3_MMIO_EN; otherwise every address is external.
module lc3_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR_in,
    input  logic        memEN,
    input  logic        RW,
    output logic        R,
    output logic [15:0] mem_data,
    output logic [15:0] ext_addr,
    output logic [15:0] ext_wdata,
    output logic        ext_we,
    output logic        ext_req,
    input  logic        ext_ack,
    input  logic [15:0] ext_rdata,
    input  logic [7:0]  kbd_data,
    input  logic        kbd_valid,
    output logic [7:0]  disp_data,
    output logic        disp_valid,
    input  logic        disp_ready,
    output logic        MCR_run,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXT  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

    localparam logic [15:0] A_KBSR = 16'hFE00;
    localparam logic [15:0] A_KBDR = 16'hFE02;
    localparam logic [15:0] A_DSR  = 16'hFE04;
    localparam logic [15:0] A_DDR  = 16'hFE06;
    localparam logic [15:0] A_MCR  = 16'hFFFE;

    state_t      state_r;
    logic [15:0] cnt_r;
    logic        rw_r;
    logic        is_dev_s;
    logic [15:0] dev_rdata_s;

`ifdef LC3_MMIO_EN
    logic [7:0]  kbd_reg_r;
    logic        kb_rdy_r;
    logic [15:0] mcr_r;
    logic        dev_acc_s;

    // Device decode and read mux, driven straight from MAR so the access completes on the request edge
    always_comb begin
        is_dev_s    = 1'b1;
        dev_rdata_s = 16'h0000;
        case (MAR)
            A_KBSR:  dev_rdata_s = {kb_rdy_r, 15'h0000};
            A_KBDR:  dev_rdata_s = {8'h00, kbd_reg_r};
            A_DSR:   dev_rdata_s = {disp_ready, 15'h0000};
            A_DDR:   dev_rdata_s = 16'h0000;
            A_MCR:   dev_rdata_s = mcr_r;
            default: is_dev_s    = 1'b0;
        endcase
    end

    assign dev_acc_s = (state_r == ST_IDLE) && memEN && is_dev_s;
    assign MCR_run   = mcr_r[15];

    // Device register side effects; a keyboard strobe outranks the KBDR read clearing kb_rdy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kbd_reg_r  <= 8'h00;
            kb_rdy_r   <= 1'b0;
            mcr_r      <= 16'h8000;
            disp_data  <= 8'h00;
            disp_valid <= 1'b0;
        end else begin
            disp_valid <= 1'b0;
            if (dev_acc_s && RW && (MAR == A_DDR)) begin
                disp_data  <= MDR_in[7:0];
                disp_valid <= 1'b1;
            end
            if (dev_acc_s && RW && (MAR == A_MCR)) begin
                mcr_r <= MDR_in;
            end
            if (kbd_valid) begin
                kbd_reg_r <= kbd_data;
                kb_rdy_r  <= 1'b1;
            end else if (dev_acc_s && !RW && (MAR == A_KBDR)) begin
                kb_rdy_r <= 1'b0;
            end
        end
    end
`else
    logic unused_s;

    assign is_dev_s    = 1'b0;
    assign dev_rdata_s = 16'h0000;
    assign disp_data   = 8'h00;
    assign disp_valid  = 1'b0;
    assign MCR_run     = 1'b1;
    assign unused_s    = ^{kbd_data, kbd_valid, disp_ready};
`endif

    // Access sequencer: IDLE captures the request, EXT runs the handshake, DONE presents R for one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 16'h0000;
            rw_r      <= 1'b0;
            R         <= 1'b0;
            mem_data  <= 16'h0000;
            ext_addr  <= 16'h0000;
            ext_wdata <= 16'h0000;
            ext_we    <= 1'b0;
            ext_req   <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            R <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (memEN) begin
                        ext_addr  <= MAR;
                        ext_wdata <= MDR_in;
                        rw_r      <= RW;
                        if (is_dev_s) begin
                            if (!RW) begin
                                mem_data <= dev_rdata_s;
                            end
                            R       <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            ext_req <= 1'b1;
                            ext_we  <= RW;
                            cnt_r   <= 16'h0000;
                            state_r <= ST_EXT;
                        end
                    end
                end
                ST_EXT: begin
                    if (ext_ack) begin
                        if (!rw_r) begin
                            mem_data <= ext_rdata;
                        end
                        ext_req <= 1'b0;
                        ext_we  <= 1'b0;
                        R       <= 1'b1;
                        state_r <= ST_DONE;
                    end else if (cnt_r == TO_LAST) begin
                        // No ack within the budget: complete anyway with zero data and flag the error
                        mem_data <= 16'h0000;
                        bus_err  <= 1'b1;
                        ext_req  <= 1'b0;
                        ext_we   <= 1'b0;
                        R        <= 1'b1;
                        state_r  <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    ext_req <= 1'b0;
                    ext_we  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Table-driven bench for lc3_mem_ctrl (TIMEOUT_CYCLES=4); device rows only when LC3_MMIO_EN is defined.
module tb_lc3_mem_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] MAR;
    logic [15:0] MDR_in;
    logic        memEN;
    logic        RW;
    logic        R;
    logic [15:0] mem_data;
    logic [15:0] ext_addr;
    logic [15:0] ext_wdata;
    logic        ext_we;
    logic        ext_req;
    logic        ext_ack;
    logic [15:0] ext_rdata;
    logic [7:0]  kbd_data;
    logic        kbd_valid;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic        disp_ready;
    logic        MCR_run;
    logic        bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    lc3_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .MAR(MAR), .MDR_in(MDR_in), .memEN(memEN), .RW(RW),
        .R(R), .mem_data(mem_data), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_we(ext_we), .ext_req(ext_req), .ext_ack(ext_ack), .ext_rdata(ext_rdata),
        .kbd_data(kbd_data), .kbd_valid(kbd_valid), .disp_data(disp_data),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .MCR_run(MCR_run), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] mar;
        logic [15:0] wdata;
        logic        rw;
        int          ack_at;
        logic [15:0] rdata;
        logic        is_ext;
        int          exp_lat;
        logic        chk_md;
        logic [15:0] exp_md;
        logic        exp_err;
        logic        exp_run;
        logic        kb_pre;
        logic        kb_same;
        logic [7:0]  kb_char;
        logic        chk_disp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] mar, input logic [15:0] wdata, input logic rw,
                                input int ack_at, input logic [15:0] rdata, input logic is_ext,
                                input int exp_lat, input logic chk_md, input logic [15:0] exp_md,
                                input logic exp_err, input logic exp_run);
        vec_t v;
        v.mar = mar; v.wdata = wdata; v.rw = rw; v.ack_at = ack_at; v.rdata = rdata;
        v.is_ext = is_ext; v.exp_lat = exp_lat; v.chk_md = chk_md; v.exp_md = exp_md;
        v.exp_err = exp_err; v.exp_run = exp_run;
        v.kb_pre = 1'b0; v.kb_same = 1'b0; v.kb_char = 8'h00; v.chk_disp = 1'b0;
        return v;
    endfunction

    function automatic vec_t ext_rd(input logic [15:0] mar, input int ack_at, input logic [15:0] rd,
                                    input int lat, input logic [15:0] md, input logic err);
        return mk(mar, 16'h0000, 1'b0, ack_at, rd, 1'b1, lat, 1'b1, md, err, 1'b1);
    endfunction

    function automatic vec_t dev_rd(input logic [15:0] mar, input logic [15:0] md,
                                    input logic err, input logic run);
        return mk(mar, 16'h0000, 1'b0, 0, 16'h0000, 1'b0, 1, 1'b1, md, err, run);
    endfunction

    function automatic vec_t dev_wr(input logic [15:0] mar, input logic [15:0] wd,
                                    input logic err, input logic run);
        return mk(mar, wd, 1'b1, 0, 16'h0000, 1'b0, 1, 1'b0, 16'h0000, err, run);
    endfunction

    task automatic run_vec(input string tag, input vec_t v);
        int   lat;
        logic saw_r;
        @(negedge clk);
        if (v.kb_pre) begin
            kbd_data  = v.kb_char;
            kbd_valid = 1'b1;
            @(negedge clk);
            kbd_valid = 1'b0;
        end
        MAR = v.mar; MDR_in = v.wdata; RW = v.rw; ext_rdata = v.rdata; memEN = 1'b1;
        if (v.kb_same) begin
            kbd_data  = v.kb_char;
            kbd_valid = 1'b1;
        end
        @(posedge clk); #1;
        kbd_valid = 1'b0;
        lat = 1;
        if (v.is_ext) begin
            chk({tag, " ext_we"}, 16'(ext_we), 16'(v.rw));
            if (v.rw) chk({tag, " ext_wdata"}, ext_wdata, v.wdata);
        end
        saw_r = 1'b0;
        while (!saw_r && lat < 40) begin
            if (R) begin
                saw_r = 1'b1;
            end else begin
                if (v.is_ext) begin
                    chk({tag, " ext_req"}, 16'(ext_req), 16'd1);
                    chk({tag, " ext_addr"}, ext_addr, v.mar);
                end
                ext_ack = (v.ack_at != 0) && (lat == v.ack_at);
                @(posedge clk); #1;
                ext_ack = 1'b0;
                lat++;
            end
        end
        memEN = 1'b0;
        chk({tag, " R seen"}, 16'(saw_r), 16'd1);
        chk({tag, " latency"}, 16'(lat), 16'(v.exp_lat));
        if (v.chk_md) chk({tag, " mem_data"}, mem_data, v.exp_md);
        chk({tag, " bus_err"}, 16'(bus_err), 16'(v.exp_err));
        chk({tag, " MCR_run"}, 16'(MCR_run), 16'(v.exp_run));
        chk({tag, " ext_req end"}, 16'(ext_req), 16'd0);
        if (v.chk_disp) begin
            chk({tag, " disp_valid"}, 16'(disp_valid), 16'd1);
            chk({tag, " disp_data"}, 16'(disp_data), {8'h00, v.wdata[7:0]});
        end
        @(posedge clk); #1;
        chk({tag, " R one cycle"}, 16'(R), 16'd0);
        if (v.chk_disp) chk({tag, " disp_valid one cycle"}, 16'(disp_valid), 16'd0);
    endtask

    initial begin
        vec_t v;
        reset = 1'b0; MAR = 16'h0000; MDR_in = 16'h0000; memEN = 1'b0; RW = 1'b0;
        ext_ack = 1'b0; ext_rdata = 16'h0000; kbd_data = 8'h00; kbd_valid = 1'b0;
        disp_ready = 1'b1;

        // Common rows: external reads/writes, ack at the timeout cycle, then a real timeout
        vecs.push_back(ext_rd(16'h3000, 1, 16'h1234, 2, 16'h1234, 1'b0));
        vecs.push_back(mk(16'h3001, 16'hBEEF, 1'b1, 1, 16'h5555, 1'b1, 2, 1'b1, 16'h1234, 1'b0, 1'b1));
        vecs.push_back(ext_rd(16'h4000, 3, 16'h0A5A, 4, 16'h0A5A, 1'b0));
        vecs.push_back(ext_rd(16'h5000, 4, 16'h7777, 5, 16'h7777, 1'b0));
`ifdef LC3_MMIO_EN
        vecs.push_back(dev_rd(16'hFE00, 16'h0000, 1'b0, 1'b1));
`else
        vecs.push_back(ext_rd(16'hFE00, 2, 16'hCAFE, 3, 16'hCAFE, 1'b0));
`endif
        vecs.push_back(ext_rd(16'h6000, 0, 16'h9999, 5, 16'h0000, 1'b1));
        vecs.push_back(ext_rd(16'h3002, 1, 16'h1111, 2, 16'h1111, 1'b1));
`ifdef LC3_MMIO_EN
        v = dev_rd(16'hFE00, 16'h8000, 1'b1, 1'b1); v.kb_pre = 1'b1; v.kb_char = 8'h41;
        vecs.push_back(v);
        vecs.push_back(dev_rd(16'hFE02, 16'h0041, 1'b1, 1'b1));
        vecs.push_back(dev_rd(16'hFE00, 16'h0000, 1'b1, 1'b1));
        v = dev_rd(16'hFE02, 16'h0041, 1'b1, 1'b1); v.kb_same = 1'b1; v.kb_char = 8'h42;
        vecs.push_back(v);
        vecs.push_back(dev_rd(16'hFE00, 16'h8000, 1'b1, 1'b1));
        vecs.push_back(dev_rd(16'hFE02, 16'h0042, 1'b1, 1'b1));
        vecs.push_back(dev_rd(16'hFE04, 16'h8000, 1'b1, 1'b1));
        vecs.push_back(dev_rd(16'hFE06, 16'h0000, 1'b1, 1'b1));
        v = dev_wr(16'hFE06, 16'h0058, 1'b1, 1'b1); v.chk_disp = 1'b1;
        vecs.push_back(v);
        vecs.push_back(dev_wr(16'hFFFE, 16'h0000, 1'b1, 1'b0));
        vecs.push_back(dev_rd(16'hFFFE, 16'h0000, 1'b1, 1'b0));
        vecs.push_back(dev_wr(16'hFFFE, 16'h8000, 1'b1, 1'b1));
        vecs.push_back(dev_rd(16'hFFFE, 16'h8000, 1'b1, 1'b1));
        vecs.push_back(dev_wr(16'hFE00, 16'h1234, 1'b1, 1'b1));
        vecs.push_back(dev_rd(16'hFE00, 16'h0000, 1'b1, 1'b1));
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst R", 16'(R), 16'd0);
        chk("rst ext_req", 16'(ext_req), 16'd0);
        chk("rst ext_we", 16'(ext_we), 16'd0);
        chk("rst disp_valid", 16'(disp_valid), 16'd0);
        chk("rst bus_err", 16'(bus_err), 16'd0);
        chk("rst mem_data", mem_data, 16'h0000);
        chk("rst ext_addr", ext_addr, 16'h0000);
        chk("rst ext_wdata", ext_wdata, 16'h0000);
        chk("rst disp_data", 16'(disp_data), 16'h0000);
        chk("rst MCR_run", 16'(MCR_run), 16'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Reset in the middle of an external access: ext_req must drop before any clock edge
        @(negedge clk);
        MAR = 16'h7000; RW = 1'b0; memEN = 1'b1;
        @(posedge clk); #1;
        chk("midrst ext_req before", 16'(ext_req), 16'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst ext_req async", 16'(ext_req), 16'd0);
        chk("midrst bus_err", 16'(bus_err), 16'd0);
        memEN = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("midrst R held%0d", c), 16'(R), 16'd0);
        end
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("midrst R after%0d", c), 16'(R) | 16'(ext_req), 16'd0);
        end
        run_vec("post_rst", ext_rd(16'h3003, 1, 16'h2468, 2, 16'h2468, 1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3_mem_ctrl.md
# lc3_mem_ctrl

Memory access controller directly downstream of the MAR register. On a memory-enable request from the control FSM it decodes the latched MAR address and completes a read or write. The target is either a memory-mapped device register (keyboard, display, machine control) or external memory over a req/ack handshake. It returns read data toward MDR and pulses `R` (ready) back to the control FSM.

## Interface
- `TIMEOUT_CYCLES`, 255: max cycles `ext_req` stays high without `ext_ack` before the access is aborted (1..65535).

- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `MAR`  in  16  access address
- `MDR_in`  in  16  write data
- `memEN`  in  1  access request (level, held by control FSM until `R`)
- `RW`  in  1  1 = write, 0 = read
- `R`  out  1  access-complete pulse, one cycle
- `mem_data`  out  16  read data, valid while `R`=1
- `ext_addr` / `ext_wdata`  out  16  external memory address / write data
- `ext_we`  out  1  external write strobe qualifier
- `ext_req`  out  1  external access request
- `ext_ack`  in  1  external access complete (read data valid same cycle)
- `ext_rdata`  in  16  external read data
- `kbd_data`  in  8  keyboard character
- `kbd_valid`  in  1  one-cycle keyboard strobe
- `disp_data`  out  8  display character
- `disp_valid`  out  1  one-cycle display strobe
- `disp_ready`  in  1  display can accept a character
- `MCR_run`  out  1  MCR[15], clock-enable for the core
- `bus_err`  out  1  sticky external-timeout flag

## Operation
- States: IDLE, EXT, DONE.
- IDLE: when `memEN`=1, capture `MAR`, `MDR_in`, `RW` into internal regs.
  - Device address → DONE.
  - Otherwise → EXT.
- Device map:
  - xFE00 KBSR: read = {kb_rdy,15'b0}
  - xFE02 KBDR: read = {8'b0,kbd_reg}; read clears kb_rdy
  - xFE04 DSR: read = {disp_ready,15'b0}
  - xFE06 DDR: write loads `disp_data` = MDR[7:0] and pulses `disp_valid`
  - xFFFE MCR: read/write full 16 bits
- Writes to KBSR, KBDR, DSR are ignored. Reads of DDR return x0000.
- Any other address is external.
- `kbd_valid`=1: `kbd_reg` ← `kbd_data`, kb_rdy ← 1, in any state.
  - Same cycle as a KBDR read completing: set dominates, kb_rdy stays 1. The read returns the old `kbd_reg`.
- EXT: `ext_req`=1, `ext_addr`/`ext_wdata`/`ext_we` driven from captured regs.
  - `ext_ack` sampled 1 → latch `ext_rdata` into `mem_data` (reads) and go to DONE.
  - A 16-bit counter counts EXT cycles. When it reaches `TIMEOUT_CYCLES` with no ack: `mem_data` ← x0000, `bus_err` ← 1, go to DONE.
  - Ack on the timeout cycle: ack wins, no error.
- DONE: `R`=1 for exactly one cycle, `mem_data` held, then → IDLE.
- `memEN` is ignored outside IDLE. `memEN` still high in IDLE after DONE is a new access.
- Reset values: `R`, `ext_req`, `ext_we`, `disp_valid`, `bus_err`, kb_rdy = 0. `mem_data`, `ext_addr`, `ext_wdata`, `kbd_reg`, `disp_data` = 0. MCR = x8000, so `MCR_run`=1. State = IDLE.
- Reset mid-access aborts immediately: `ext_req` drops asynchronously and no `R` is issued.

## Timing
- `memEN` sampled at edge k.
- Device access: `R`=1 in cycle k+1. `disp_valid` and the MCR update become visible in the same cycle.
- External: `ext_req` high from edge k. Ack sampled at edge k+n (n≥1) → `R` in cycle k+n+1. Minimum latency is 2 cycles.
- Timeout: `R` in cycle k+`TIMEOUT_CYCLES`+1.
- `ext_addr`/`ext_wdata`/`ext_we` are stable for the whole `ext_req` window.

## Configuration
- `LC3_MMIO_EN` defined: device decode as above.
- Undefined: no decode, every address goes to external memory.
  - `disp_valid`, `disp_data` tied 0; `MCR_run` tied 1.
  - Keyboard inputs are ignored.

## Test plan
- Reset low, then high → all outputs at reset values, `MCR_run`=1, state IDLE.
- Read x3000, ack on first req cycle with `ext_rdata`=x1234 → `R` at k+2, `mem_data`=x1234. Write x3001 data xBEEF → `ext_we`=1, `ext_wdata`=xBEEF.
- `kbd_valid` with x41, then read KBSR → x8000. Read KBDR → x0041, and a following KBSR read → x0000. Strobe on the KBDR completion cycle → kb_rdy stays 1.
- Write DDR x0058 → `disp_valid` one cycle, `disp_data`=x58, `R` at k+1. Write MCR x0000 → `MCR_run`=0.
- `TIMEOUT_CYCLES`=4, no ack → `R` at k+5, `mem_data`=x0000, `bus_err`=1. Same run with ack at the 4th cycle → no error.
- Assert reset during EXT → `ext_req` drops asynchronously, no `R`. With `LC3_MMIO_EN` undefined, read xFE00 → goes external.
